sdram_cmd_responder: RTL and testbench

//  Target-side model of a single-bank SDR SDRAM. It sits on the pins driven by sdram_controller
//  (cs/ras/cas/we/address bus plus data) and is used as a loopback target and bring-up partner.
//  It decodes commands, tracks the open row, honours mode-register CAS latency and burst length,

---
 rtl/sdram_cmd_responder.sv | 203 ++++++++++++++++++++
 tb/tb_sdram_cmd_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_responder.sv
// Single-bank SDR SDRAM target: decodes controller commands, tracks the open row,
// runs CL/BL-aware read/write bursts against a flop array and flags protocol violations.
module sdram_cmd_responder #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 4,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int T_RFC    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdram_cs,
  input  logic              sdram_ras,
  input  logic              sdram_cas,
  input  logic              sdram_we,
  input  logic [ADDR_W-1:0] sdram_addr,
  input  logic [DATA_W-1:0] sdram_dq_in,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe,
  output logic [1:0]        state_out,
  output logic              cmd_err
);
  localparam int DEPTH = 2**(ROW_BITS + COL_BITS);
  localparam int RFC_W = $clog2(T_RFC + 1);

  localparam logic [2:0] CMD_LMR = 3'b000;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_BST = 3'b110;
  localparam logic [2:0] CMD_NOP = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_REFRESH = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [2:0] cmd;
  logic       cmd_nop;
  logic [2:0] mode_cl, mode_bl;
  logic       mode_ok;
  logic       unused_addr;

  logic                err, act_en, lmr_en, rfc_load, rd_start, wr_start, pre;
  logic [ROW_BITS-1:0] row;
  logic [1:0]          cl;
  logic [2:0]          bl_len;
  logic [RFC_W-1:0]    rfc_cnt;

  logic [COL_BITS-1:0] b_col, b_mask;
  logic [2:0]          b_k, b_left;
  logic                b_wr;

  logic                         beat_vld, beat_wr;
  logic [COL_BITS-1:0]          beat_col;
  logic [ROW_BITS+COL_BITS-1:0] beat_addr;
  logic [DATA_W-1:0]            rd_data;

  logic [2:0]             pipe_vld;
  logic [2:0][DATA_W-1:0] pipe_dat;
  logic [DATA_W-1:0]      mem [DEPTH];

  assign cmd         = sdram_cs ? CMD_NOP : {sdram_ras, sdram_cas, sdram_we};
  assign cmd_nop     = (cmd == CMD_NOP) || (cmd == CMD_BST);
  assign mode_cl     = sdram_addr[6:4];
  assign mode_bl     = sdram_addr[2:0];
  assign mode_ok     = ((mode_cl == 3'd2) || (mode_cl == 3'd3)) && (mode_bl <= 3'd2);
  assign unused_addr = ^sdram_addr;
  assign state_out   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    err      = 1'b0;
    act_en   = 1'b0;
    lmr_en   = 1'b0;
    rfc_load = 1'b0;
    rd_start = 1'b0;
    wr_start = 1'b0;
    pre      = 1'b0;
    case (state)
      ST_IDLE: begin
        case (cmd)
          CMD_ACT: begin act_en = 1'b1; state_nx = ST_ACTIVE; end
          CMD_REF: begin rfc_load = 1'b1; state_nx = ST_REFRESH; end
          CMD_LMR: begin
            if (mode_ok) lmr_en = 1'b1;
            else         err    = 1'b1;
          end
          CMD_RD, CMD_WR: err = 1'b1;
          default: ;
        endcase
      end
      ST_ACTIVE: begin
        case (cmd)
          CMD_RD:  rd_start = 1'b1;
          CMD_WR:  wr_start = 1'b1;
          CMD_PRE: begin pre = 1'b1; state_nx = ST_IDLE; end
          CMD_ACT, CMD_REF, CMD_LMR: err = 1'b1;
          default: ;
        endcase
      end
      ST_REFRESH: begin
        err = !cmd_nop;
        if (rfc_cnt <= RFC_W'(1)) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row     <= '0;
      cl      <= 2'd2;
      bl_len  <= 3'd1;
      rfc_cnt <= '0;
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= err;
      if (act_en) row <= sdram_addr[ROW_BITS-1:0];
      if (lmr_en) begin
        cl     <= mode_cl[1:0];
        bl_len <= 3'd1 << mode_bl[1:0];
      end
      if (rfc_load)                                    rfc_cnt <= RFC_W'(T_RFC);
      else if (state == ST_REFRESH && rfc_cnt != '0)   rfc_cnt <= rfc_cnt - RFC_W'(1);
    end
  end

  // Beat 0 comes straight from the command; later beats wrap inside the aligned burst block.
  always_comb begin
    beat_vld = 1'b0;
    beat_wr  = 1'b0;
    beat_col = '0;
    if (rd_start || wr_start) begin
      beat_vld = 1'b1;
      beat_wr  = wr_start;
      beat_col = sdram_addr[COL_BITS-1:0];
    end else if (b_left != 3'd0 && !pre) begin
      beat_vld = 1'b1;
      beat_wr  = b_wr;
      beat_col = (b_col & ~b_mask) | ((b_col + COL_BITS'(b_k)) & b_mask);
    end
  end

  assign beat_addr = {row, beat_col};
  assign rd_data   = mem[beat_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_col  <= '0;
      b_mask <= '0;
      b_k    <= 3'd0;
      b_left <= 3'd0;
      b_wr   <= 1'b0;
    end else if (rd_start || wr_start) begin
      b_col  <= sdram_addr[COL_BITS-1:0];
      b_mask <= COL_BITS'(bl_len - 3'd1);
      b_wr   <= wr_start;
      b_k    <= 3'd1;
      b_left <= bl_len - 3'd1;
    end else if (pre) begin
      b_left <= 3'd0;
    end else if (b_left != 3'd0) begin
      b_k    <= b_k + 3'd1;
      b_left <= b_left - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_vld && beat_wr) mem[beat_addr] <= sdram_dq_in;
  end

  // Slot j emerges j+1 edges from now; a new read beat lands in slot CL-1.
  // A WRITE drops every beat not yet presented, including one due on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld     <= '0;
      pipe_dat     <= '0;
      sdram_dq_oe  <= 1'b0;
      sdram_dq_out <= '0;
    end else begin
      sdram_dq_oe <= pipe_vld[0] && !wr_start;
      if (pipe_vld[0] && !wr_start) sdram_dq_out <= pipe_dat[0];
      pipe_vld <= wr_start ? 3'b000 : {1'b0, pipe_vld[2:1]};
      pipe_dat <= {{DATA_W{1'b0}}, pipe_dat[2:1]};
      if (beat_vld && !beat_wr) begin
        pipe_vld[cl - 2'd1] <= 1'b1;
        pipe_dat[cl - 2'd1] <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Bench for sdram_cmd_responder: directed scenarios plus random command traffic,
// all checked against a cycle-level behavioural model of the SDRAM target.
module tb_sdram_cmd_responder;
  localparam int ROW_BITS = 4, COL_BITS = 4, ADDR_W = 12, DATA_W = 8, T_RFC = 4;
  localparam int COLS = 2**COL_BITS;
  localparam int CELLS = 2**(ROW_BITS + COL_BITS);

  localparam logic [2:0] LMR = 3'b000, REF = 3'b001, PRE = 3'b010, ACT = 3'b011;
  localparam logic [2:0] WR = 3'b100, RD = 3'b101, BST = 3'b110, NOP = 3'b111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs = 1'b1, ras = 1'b1, cas = 1'b1, we = 1'b1;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] dq_in = '0;
  logic [DATA_W-1:0] dq_out;
  logic dq_oe, cmd_err;
  logic [1:0] state_out;

  sdram_cmd_responder #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .ADDR_W(ADDR_W),
                        .DATA_W(DATA_W), .T_RFC(T_RFC)) dut (
    .clk(clk), .rst_n(rst_n), .sdram_cs(cs), .sdram_ras(ras), .sdram_cas(cas),
    .sdram_we(we), .sdram_addr(addr), .sdram_dq_in(dq_in), .sdram_dq_out(dq_out),
    .sdram_dq_oe(dq_oe), .state_out(state_out), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_state, m_row, m_cl, m_bl, m_rfc, cyc;
  int b_col, b_k, b_len, b_left;
  bit b_wr;
  bit sv [64];
  logic [DATA_W-1:0] sd [64];
  logic [DATA_W-1:0] mmem [CELLS];
  logic [DATA_W-1:0] e_dq;
  bit e_oe, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_row = 0; m_cl = 2; m_bl = 1; m_rfc = 0;
    b_col = 0; b_k = 0; b_len = 1; b_left = 0; b_wr = 0;
    for (int i = 0; i < 64; i++) sv[i] = 0;
    e_dq = '0; e_oe = 0; e_err = 0;
  endtask

  task automatic model_edge(input logic c_cs, input logic [2:0] c, input logic [11:0] a,
                            input logic [7:0] d);
    int cmd, nxt, col, slot;
    bit new_rd, new_wr, kill;
    cmd = c_cs ? 7 : int'(c);
    nxt = m_state; e_err = 0; new_rd = 0; new_wr = 0; kill = 0;
    cyc++;
    case (m_state)
      0: begin
        if (cmd == 3) begin m_row = int'(a[3:0]); nxt = 1; end
        else if (cmd == 1) begin m_rfc = T_RFC; nxt = 2; end
        else if (cmd == 0) begin
          if ((a[6:4] == 3'd2 || a[6:4] == 3'd3) && a[2:0] <= 3'd2) begin
            m_cl = int'(a[6:4]);
            m_bl = 1 << a[2:0];
          end else e_err = 1;
        end else if (cmd == 5 || cmd == 4) e_err = 1;
      end
      1: begin
        if (cmd == 5) new_rd = 1;
        else if (cmd == 4) new_wr = 1;
        else if (cmd == 2) begin kill = 1; nxt = 0; end
        else if (cmd == 3 || cmd == 1 || cmd == 0) e_err = 1;
      end
      default: begin
        if (cmd != 7 && cmd != 6) e_err = 1;
        m_rfc--;
        if (m_rfc == 0) nxt = 0;
      end
    endcase
    if (new_wr) for (int i = 0; i < 64; i++) sv[i] = 0;
    slot = cyc % 64;
    e_oe = sv[slot];
    if (e_oe) e_dq = sd[slot];
    sv[slot] = 0;
    if (new_rd || new_wr) begin
      b_col = int'(a[3:0]); b_k = 0; b_len = m_bl; b_wr = new_wr; b_left = m_bl;
    end else if (kill) b_left = 0;
    if (b_left > 0) begin
      col = b_col - (b_col % b_len) + ((b_col + b_k) % b_len);
      if (b_wr) mmem[m_row*COLS + col] = d;
      else begin
        sv[(cyc + m_cl) % 64] = 1;
        sd[(cyc + m_cl) % 64] = mmem[m_row*COLS + col];
      end
      b_k++;
      b_left--;
    end
    m_state = nxt;
  endtask

  task automatic step(input logic c_cs, input logic [2:0] c, input logic [11:0] a,
                      input logic [7:0] d);
    cs = c_cs; {ras, cas, we} = c; addr = a; dq_in = d;
    @(posedge clk);
    model_edge(c_cs, c, a, d);
    #1;
    chk("dq_oe", 32'(dq_oe), 32'(e_oe));
    chk("dq_out", 32'(dq_out), 32'(e_dq));
    chk("state", 32'(state_out), 32'(m_state));
    chk("cmd_err", 32'(cmd_err), 32'(e_err));
  endtask

  task automatic cmd1(input logic [2:0] c, input logic [11:0] a, input logic [7:0] d);
    step(1'b0, c, a, d);
  endtask

  initial begin
    logic [7:0] bl4_exp [4];
    logic [11:0] ra;
    int n;
    bl4_exp[0] = 8'h11; bl4_exp[1] = 8'h22; bl4_exp[2] = 8'h33; bl4_exp[3] = 8'h44;
    model_reset();
    cyc = 0;
    #1;
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_oe", 32'(dq_oe), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    chk("rst_dq", 32'(dq_out), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    cmd1(RD, 12'h000, 8'h00);
    chk("idle_read_err", 32'(cmd_err), 32'd1);
    cmd1(NOP, 12'h000, 8'h00);
    chk("err_pulse_end", 32'(cmd_err), 32'd0);

    // give every cell a known value
    for (int r = 0; r < 2**ROW_BITS; r++) begin
      cmd1(ACT, 12'(r), 8'h00);
      for (int c = 0; c < COLS; c++) cmd1(WR, 12'(c), 8'($urandom));
      cmd1(PRE, 12'h000, 8'h00);
    end

    // CL2 / BL1 single beat
    cmd1(ACT, 12'h003, 8'h00);
    cmd1(WR, 12'h005, 8'hA5);
    cmd1(NOP, 12'h000, 8'h00);
    cmd1(RD, 12'h005, 8'h00);
    chk("cl2_t0_oe", 32'(dq_oe), 32'd0);
    cmd1(NOP, 12'h000, 8'h00);
    chk("cl2_t1_oe", 32'(dq_oe), 32'd0);
    cmd1(NOP, 12'h000, 8'h00);
    chk("cl2_t2_oe", 32'(dq_oe), 32'd1);
    chk("cl2_t2_dq", 32'(dq_out), 32'hA5);
    cmd1(NOP, 12'h000, 8'h00);
    chk("cl2_t3_oe", 32'(dq_oe), 32'd0);
    chk("cl2_hold_dq", 32'(dq_out), 32'hA5);

    // CL3 / BL4 wrapping burst
    cmd1(PRE, 12'h000, 8'h00);
    cmd1(LMR, 12'h032, 8'h00);
    cmd1(ACT, 12'h003, 8'h00);
    cmd1(WR, 12'h006, 8'h11);
    cmd1(NOP, 12'h000, 8'h22);
    cmd1(NOP, 12'h000, 8'h33);
    cmd1(NOP, 12'h000, 8'h44);
    cmd1(NOP, 12'h000, 8'h00);
    cmd1(RD, 12'h006, 8'h00);
    cmd1(NOP, 12'h000, 8'h00);
    cmd1(NOP, 12'h000, 8'h00);
    chk("cl3_t2_oe", 32'(dq_oe), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cmd1(NOP, 12'h000, 8'h00);
      chk("bl4_oe", 32'(dq_oe), 32'd1);
      chk("bl4_dq", 32'(dq_out), 32'(bl4_exp[i]));
    end

    // PRECHARGE two cycles into a BL4 read
    cmd1(RD, 12'h006, 8'h00);
    n = 0;
    cmd1(NOP, 12'h000, 8'h00);
    cmd1(PRE, 12'h000, 8'h00);
    for (int i = 0; i < 6; i++) begin
      cmd1(NOP, 12'h000, 8'h00);
      if (dq_oe) n++;
    end
    chk("pre_beats", 32'(n), 32'd2);
    chk("pre_state", 32'(state_out), 32'd0);

    // refresh window, ACTIVE rejected inside it
    n = 0;
    cmd1(REF, 12'h000, 8'h00);
    if (state_out == 2'd2) n++;
    cmd1(ACT, 12'h007, 8'h00);
    if (state_out == 2'd2) n++;
    chk("ref_act_err", 32'(cmd_err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cmd1(NOP, 12'h000, 8'h00);
      if (state_out == 2'd2) n++;
    end
    chk("ref_cycles", 32'(n), 32'd4);
    chk("ref_no_open", 32'(state_out), 32'd0);

    // illegal CL leaves CL3 in force
    cmd1(LMR, 12'h052, 8'h00);
    chk("bad_cl_err", 32'(cmd_err), 32'd1);
    cmd1(ACT, 12'h003, 8'h00);
    cmd1(RD, 12'h005, 8'h00);
    cmd1(NOP, 12'h000, 8'h00);
    cmd1(NOP, 12'h000, 8'h00);
    chk("keep_cl_t2", 32'(dq_oe), 32'd0);
    cmd1(NOP, 12'h000, 8'h00);
    chk("keep_cl_t3_oe", 32'(dq_oe), 32'd1);
    chk("keep_cl_t3_dq", 32'(dq_out), 32'h44);
    for (int i = 0; i < 4; i++) cmd1(NOP, 12'h000, 8'h00);

    // asynchronous reset in the middle of a read burst
    cmd1(RD, 12'h006, 8'h00);
    for (int i = 0; i < 3; i++) cmd1(NOP, 12'h000, 8'h00);
    chk("mid_burst_oe", 32'(dq_oe), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_oe", 32'(dq_oe), 32'd0);
    chk("arst_state", 32'(state_out), 32'd0);
    chk("arst_err", 32'(cmd_err), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cmd1(RD, 12'h000, 8'h00);
    chk("post_rst_rd_err", 32'(cmd_err), 32'd1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [2:0] c;
      r = $urandom_range(0, 99);
      if (r < 25) c = RD;
      else if (r < 45) c = WR;
      else if (r < 65) c = NOP;
      else if (r < 75) c = ACT;
      else if (r < 83) c = PRE;
      else if (r < 87) c = REF;
      else if (r < 95) c = LMR;
      else c = BST;
      ra = 12'($urandom);
      if (c == LMR && $urandom_range(0, 9) < 7) begin
        ra[6:4] = 3'($urandom_range(2, 3));
        ra[2:0] = 3'($urandom_range(0, 2));
      end
      step(($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0, c, ra, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
